// File: rtl/global_ldst_distributor.sv
// Splits one vector load/store into per-cluster sub-requests and retires it once every cluster reports done.
// Optional feature macro: GLOBAL_LDST_STRIDED_EN (adds req_stride_i; cluster offsets use the byte stride).
package global_ldst_pkg;
    typedef struct packed {
        logic       vill;
        logic [2:0] sew;   // log2 of element size in bytes
    } vtype_t;
endpackage

module global_ldst_distributor
    import global_ldst_pkg::*;
#(
    parameter int unsigned NrLanes    = 4,
    parameter int unsigned NrClusters = 4,
    parameter int unsigned VlClWidth  = 16,
    parameter int unsigned AddrWidth  = 64,
    localparam int unsigned ClBits    = $clog2(NrClusters),
    localparam int unsigned VlWidth   = VlClWidth - ClBits
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [VlClWidth-1:0]                 vl_i,
    input  vtype_t                               vtype_i,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic [AddrWidth-1:0]                 req_addr_i,
    input  logic                                 req_store_i,
`ifdef GLOBAL_LDST_STRIDED_EN
    input  logic [AddrWidth-1:0]                 req_stride_i,
`endif
    output logic [NrClusters-1:0]                cl_valid_o,
    input  logic [NrClusters-1:0]                cl_ready_i,
    output logic [NrClusters-1:0][AddrWidth-1:0] cl_addr_o,
    output logic [VlWidth-1:0]                   cl_vl_o,
    output logic                                 cl_store_o,
    input  logic [NrClusters-1:0]                cl_done_i,
    output logic                                 done_o,
    output logic                                 error_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e                               state_reg;
    logic [NrClusters-1:0]                issued_mask_reg;
    logic [NrClusters-1:0]                done_mask_reg;
    logic [NrClusters-1:0]                issued_mask_next;
    logic [NrClusters-1:0]                done_mask_next;
    logic [NrClusters-1:0][AddrWidth-1:0] cl_addr_next;

    // Per-cluster base addresses are formed from the request as it is accepted and then held.
    for (genvar gi = 0; gi < NrClusters; gi++) begin : g_addr
`ifdef GLOBAL_LDST_STRIDED_EN
        assign cl_addr_next[gi] = req_addr_i + AddrWidth'(gi * NrLanes) * req_stride_i;
`else
        assign cl_addr_next[gi] = req_addr_i + (AddrWidth'(gi * NrLanes) << vtype_i.sew);
`endif
    end

    // A done is only credited to a cluster that has been, or is just now being, issued.
    always_comb begin
        issued_mask_next = issued_mask_reg | (cl_ready_i & cl_valid_o);
        done_mask_next   = done_mask_reg | (cl_done_i & issued_mask_next);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg       <= IDLE;
            issued_mask_reg <= '0;
            done_mask_reg   <= '0;
            req_ready_o     <= 1'b1;
            cl_valid_o      <= '0;
            cl_addr_o       <= '0;
            cl_vl_o         <= '0;
            cl_store_o      <= 1'b0;
            done_o          <= 1'b0;
            error_o         <= 1'b0;
        end else begin
            done_o  <= 1'b0;
            error_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid_i) begin
                        if (vtype_i.vill) begin
                            error_o <= 1'b1;
                        end else if (vl_i == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            state_reg       <= ISSUE;
                            req_ready_o     <= 1'b0;
                            issued_mask_reg <= '0;
                            done_mask_reg   <= '0;
                            cl_valid_o      <= '1;
                            cl_addr_o       <= cl_addr_next;
                            cl_vl_o         <= VlWidth'(vl_i >> ClBits);
                            cl_store_o      <= req_store_i;
                        end
                    end
                end
                ISSUE, WAIT: begin
                    issued_mask_reg <= issued_mask_next;
                    done_mask_reg   <= done_mask_next;
                    cl_valid_o      <= ~issued_mask_next;
                    if (&issued_mask_next && &done_mask_next) begin
                        state_reg   <= IDLE;
                        done_o      <= 1'b1;
                        req_ready_o <= 1'b1;
                    end else if (&issued_mask_next) begin
                        state_reg <= WAIT;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    req_ready_o <= 1'b1;
                    cl_valid_o  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/global_ldst_distributor.md
# global_ldst_distributor

Splits one vector load/store request from the front end into per-cluster sub-requests, using the vl/vtype state held by the global dispatcher. It sits directly downstream of the global dispatcher and upstream of the per-cluster VLSUs. It computes each cluster's element count and base address, then issues to every cluster with independent handshakes. It waits for all clusters to complete before retiring the request.

## Interface
- NrLanes, 0: lanes per cluster; power of two, ≥1
- NrClusters, 0: number of clusters; power of two, ≥2
- vlen_cl_t, logic: global vl type (same type the dispatcher outputs)
- vlen_t, logic: per-cluster vl type, $bits(vlen_cl_t) - $clog2(NrClusters) bits
- AddrWidth, 64: address width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- vl_i  in  vlen_cl_t  current global vl
- vtype_i  in  vtype_t  current vtype
- req_valid_i  in  1  memory request valid
- req_ready_o  out  1  request accepted
- req_addr_i  in  AddrWidth  base address
- req_store_i  in  1  1 = store, 0 = load
- req_stride_i  in  AddrWidth  byte stride (only with GLOBAL_LDST_STRIDED_EN)
- cl_valid_o  out  NrClusters  per-cluster request valid
- cl_ready_i  in  NrClusters  per-cluster accept
- cl_addr_o  out  NrClusters×AddrWidth  per-cluster base address
- cl_vl_o  out  vlen_t  per-cluster vl (shared by all clusters)
- cl_store_o  out  1  latched store flag
- cl_done_i  in  NrClusters  per-cluster completion pulse
- done_o  out  1  request retired (one-cycle pulse)
- error_o  out  1  request rejected (one-cycle pulse)

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, latch addr, store flag, stride, vl_i and vtype_i.sew.
- Transitions out of IDLE on acceptance:
  - vtype_i.vill = 1: error_o pulses next cycle; stay IDLE.
  - vl_i = 0: done_o pulses next cycle; nothing is issued; stay IDLE.
  - Otherwise: go to ISSUE, with issued_mask = 0 and done_mask = 0.
- cl_vl_o = vl_q >> $clog2(NrClusters). The dispatcher guarantees vl is a multiple of NrClusters·NrLanes, so the division is exact.
- Cluster c address: addr_q + c·NrLanes·E, where E = (1 << sew) bytes. With strides enabled, E = stride_q instead. Arithmetic wraps modulo 2^AddrWidth.
- ISSUE:
  - cl_valid_o[c] = ~issued_mask[c].
  - cl_ready_i[c] & cl_valid_o[c] sets issued_mask[c].
  - Clusters are accepted independently and in any order. valid stays high until accepted; addr and vl stay stable while valid.
- Done tracking:
  - cl_done_i[c] sets done_mask[c] in ISSUE or WAIT.
  - A done on a cluster whose issued_mask bit is still 0 is illegal; the bench asserts on it and the RTL ignores it.
  - A done arriving in the same cycle as its own handshake is accepted.
- Transitions out of ISSUE:
  - To WAIT once all issued_mask bits are set.
  - If all done_mask bits are also set at that point, go directly to retire.
- Retire: when done_mask is all ones, done_o pulses for one cycle and the FSM returns to IDLE.
- Reset mid-operation: FSM returns to IDLE, masks clear, outputs return to their reset values. Outstanding cluster work is abandoned.

## Timing
- Reset values:
  - req_ready_o = 1
  - cl_valid_o = 0
  - cl_addr_o = 0
  - cl_vl_o = 0
  - cl_store_o = 0
  - done_o = 0
  - error_o = 0
- Request accepted in cycle T → cl_valid_o high from T+1.
- Last required cl_done_i in cycle D → done_o = 1 in D+1. req_ready_o = 1 in D+1, so a back-to-back request can be accepted in D+1.
- vill or vl = 0 accepted in cycle T → error_o or done_o in T+1. req_ready_o stays 1 throughout.
- All outputs are registered; there is no combinational path from cl_ready_i or cl_done_i to any output.
- vl_i and vtype_i are sampled only at acceptance. Later dispatcher updates do not affect an in-flight request.

## Configuration
- GLOBAL_LDST_STRIDED_EN:
  - Defined: the req_stride_i port exists, and the cluster offset uses the latched stride.
  - Undefined: the port is absent, and the offset uses the element size (1 << sew), i.e. unit-stride only.

## Test plan
- NrClusters=4, NrLanes=4, vl=32, sew=32b, addr=0x1000, all ready at once → cl_vl_o=8; addresses 0x1000/0x1010/0x1020/0x1030; dones in one cycle D → done_o at D+1.
- Staggered readiness: cluster 2 ready 5 cycles late, other clusters ready → cl_valid_o[2] held with stable address; the others drop after their handshake.
- vl=0 request → no cl_valid_o; done_o pulses at T+1; next request accepted at T+1.
- vill=1 request → error_o at T+1; no cluster activity.
- Strided (macro on), stride=0x40, NrLanes=4 → cluster 1 address = base+0x100. Address wrap: base=0xFFFF_FFFF_FFFF_FFF0 → cluster 1 address = 0x0000_0000_0000_00F0.
- Reset asserted in WAIT with two dones pending → after reset: IDLE, req_ready_o=1, no spurious done_o.
